// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// ---------------------------------------------------------------------------
// Frame-level controller that sits behind a UART receiver. It parses command
// frames of the form SYNC, ADDR, LEN, LEN payload bytes[, CHK] and buffers the
// payload. Only a frame that validates is committed, as a burst of one byte
// write per cycle to addresses ADDR, ADDR+1, ... (mod 256). Malformed,
// truncated and stalled frames are discarded and reported.
//
// Build option:
//   UART_CMD_CHECKSUM_EN  defined   -> trailing CHK byte (XOR of ADDR, LEN and
//                                      the payload) is required and verified.
//                         undefined -> no CHK byte; the commit starts right
//                                      after the last payload byte.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles between bytes before a partial frame is dropped
//   MAX_LEN         maximum payload length and buffer depth (1..255)
//   SYNC_BYTE       frame start marker
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   rx_valid_in     one-cycle strobe, rx_byte_in holds a received byte
//   rx_byte_in      received byte
//   wr_en_out       register write strobe
//   wr_addr_out     register write address
//   wr_data_out     register write data
//   busy_out        high whenever the parser is not idle
//   frame_done_out  one-cycle pulse, frame committed
//   frame_err_out   one-cycle pulse, frame discarded
//   err_code_out    cause of last discard: 01 length, 10 checksum, 11 timeout
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_valid_in,
    input  logic [7:0] rx_byte_in,
    output logic       wr_en_out,
    output logic [7:0] wr_addr_out,
    output logic [7:0] wr_data_out,
    output logic       busy_out,
    output logic       frame_done_out,
    output logic       frame_err_out,
    output logic [1:0] err_code_out
);

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_LEN    = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [2:0] ST_CHK    = 3'd4;
`endif
    localparam logic [2:0] ST_COMMIT = 3'd5;

    localparam logic [1:0] ERR_LEN = 2'b01;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [1:0] ERR_CHK = 2'b10;
`endif
    localparam logic [1:0] ERR_TMO = 2'b11;

`ifdef UART_CMD_CHECKSUM_EN
    // Running frame checksum: plain XOR accumulation.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    logic [2:0]       state_q,    state_d;
    logic [7:0]       addr_q,     addr_d;
    logic [IDX_W-1:0] len_q,      len_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       chk_q,      chk_d;
`endif
    logic             wr_en_q,    wr_en_d;
    logic [7:0]       wr_addr_q,  wr_addr_d;
    logic [7:0]       wr_data_q,  wr_data_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic [7:0]       pbuf_q [MAX_LEN];
    logic             buf_we_s;
    logic             timed_s;
    logic             tmo_s;
    logic [7:0]       first_byte_s;

    // Decode which states are guarded by the inter-byte timeout.
    always_comb begin
        case (state_q)
            ST_ADDR: timed_s = 1'b1;
            ST_LEN:  timed_s = 1'b1;
            ST_DATA: timed_s = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
            ST_CHK:  timed_s = 1'b1;
`endif
            default: timed_s = 1'b0;
        endcase
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
`ifdef UART_CMD_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        buf_we_s   = 1'b0;

        // A byte arriving on the expiry cycle takes priority over the timeout.
        tmo_s = timed_s && !rx_valid_in && (cnt_q == CNT_LAST);

        // When the last payload byte launches the commit directly (LEN=1, no
        // checksum), it is not in the buffer yet, so bypass it.
        if ((state_q == ST_DATA) && (idx_q == IDX_ZERO)) begin
            first_byte_s = rx_byte_in;
        end else begin
            first_byte_s = pbuf_q[0];
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_in && (rx_byte_in == SYNC_BYTE)) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_valid_in) begin
                    addr_d  = rx_byte_in;
`ifdef UART_CMD_CHECKSUM_EN
                    chk_d   = rx_byte_in;
`endif
                    state_d = ST_LEN;
                end else if (tmo_s) begin
                    err_d = 1'b1; err_code_d = ERR_TMO; state_d = ST_IDLE;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_LEN: begin
                if (rx_valid_in) begin
                    if ((rx_byte_in != 8'h00) && (rx_byte_in <= MAX_LEN_B)) begin
                        len_d   = rx_byte_in[IDX_W-1:0];
`ifdef UART_CMD_CHECKSUM_EN
                        chk_d   = chk_fold(chk_q, rx_byte_in);
`endif
                        idx_d   = IDX_ZERO;
                        state_d = ST_DATA;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_LEN; state_d = ST_IDLE;
                    end
                end else if (tmo_s) begin
                    err_d = 1'b1; err_code_d = ERR_TMO; state_d = ST_IDLE;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (rx_valid_in) begin
                    buf_we_s = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                    chk_d    = chk_fold(chk_q, rx_byte_in);
`endif
                    if ((idx_q + IDX_ONE) == len_q) begin
`ifdef UART_CMD_CHECKSUM_EN
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_CHK;
`else
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = first_byte_s;
                        idx_d     = IDX_ONE;
                        state_d   = ST_COMMIT;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_DATA;
                    end
                end else if (tmo_s) begin
                    err_d = 1'b1; err_code_d = ERR_TMO; state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (rx_valid_in) begin
                    if (rx_byte_in == chk_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = first_byte_s;
                        idx_d     = IDX_ONE;
                        state_d   = ST_COMMIT;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_CHK; state_d = ST_IDLE;
                    end
                end else if (tmo_s) begin
                    err_d = 1'b1; err_code_d = ERR_TMO; state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHK;
                end
            end
`endif
            ST_COMMIT: begin
                // idx_q counts writes already issued; rx_valid_in is ignored.
                if (idx_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q + 8'(idx_q);
                    wr_data_d = pbuf_q[idx_q[BUF_AW-1:0]];
                    idx_d     = idx_q + IDX_ONE;
                    state_d   = ST_COMMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter restarts on every accepted byte, on every state change and
        // outside the timed states.
        if (rx_valid_in || (state_d != state_q) || !timed_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            addr_q     <= 8'h00;
            len_q      <= IDX_ZERO;
            idx_q      <= IDX_ZERO;
            cnt_q      <= CNT_ZERO;
`ifdef UART_CMD_CHECKSUM_EN
            chk_q      <= 8'h00;
`endif
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
`ifdef UART_CMD_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge clk_in) begin
        if (buf_we_s) begin
            pbuf_q[idx_q[BUF_AW-1:0]] <= rx_byte_in;
        end
    end

    assign wr_en_out      = wr_en_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;
    assign frame_err_out  = err_q;
    assign err_code_out   = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
module tb_uart_cmd_parser;

    localparam int unsigned TMO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] pl [16];
    logic       any_wr;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_LEN       (16),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rx_valid_in   (rx_valid),
        .rx_byte_in    (rx_byte),
        .wr_en_out     (wr_en),
        .wr_addr_out   (wr_addr),
        .wr_data_out   (wr_data),
        .busy_out      (busy),
        .frame_done_out(done),
        .frame_err_out (err),
        .err_code_out  (err_code)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the byte is consumed at the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] a, input int n, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) send_byte(pl[i]);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(c);
`else
        if (c == 8'h00) begin end
`endif
    endtask

    task automatic expect_commit(input string tag, input logic [7:0] a, input int n);
        logic [7:0] ea;
        for (int i = 0; i < n; i++) begin
            ea = a + 8'(i);
            check_val({tag, ".wr_en"}, {31'd0, wr_en}, 32'd1);
            check_val({tag, ".addr"}, {24'd0, wr_addr}, {24'd0, ea});
            check_val({tag, ".data"}, {24'd0, wr_data}, {24'd0, pl[i]});
            check_val({tag, ".busy"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check_val({tag, ".end_wr_en"}, {31'd0, wr_en}, 32'd0);
        check_val({tag, ".done"}, {31'd0, done}, 32'd1);
        check_val({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val({tag, ".done_drop"}, {31'd0, done}, 32'd0);
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code);
        check_val({tag, ".err"}, {31'd0, err}, 32'd1);
        check_val({tag, ".code"}, {30'd0, err_code}, {30'd0, code});
        check_val({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, ".wr_en"}, {31'd0, wr_en}, 32'd0);
        @(negedge clk);
        check_val({tag, ".err_drop"}, {31'd0, err}, 32'd0);
        check_val({tag, ".code_hold"}, {30'd0, err_code}, {30'd0, code});
    endtask

    task automatic set_pl(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        pl[0] = b0; pl[1] = b1; pl[2] = b2; pl[3] = b3;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        for (int i = 0; i < 16; i++) pl[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst.wr_en", {31'd0, wr_en}, 32'd0);
        check_val("rst.addr", {24'd0, wr_addr}, 32'd0);
        check_val("rst.data", {24'd0, wr_data}, 32'd0);
        check_val("rst.busy", {31'd0, busy}, 32'd0);
        check_val("rst.done", {31'd0, done}, 32'd0);
        check_val("rst.err", {31'd0, err}, 32'd0);
        check_val("rst.code", {30'd0, err_code}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame: 10^03^11^22^33 = 13.
        set_pl(8'h11, 8'h22, 8'h33, 8'h00);
        send_byte(8'hA5);
        check_val("a.sync_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h13);
`endif
        expect_commit("a", 8'h10, 3);

`ifdef UART_CMD_CHECKSUM_EN
        // Same frame, wrong checksum.
        send_frame(8'h10, 3, 8'h14);
        expect_err("badchk", 2'b10);
`endif

        // Illegal lengths.
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
        expect_err("len0", 2'b01);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
        expect_err("len17", 2'b01);
        send_frame(8'h10, 3, 8'h13);
        expect_commit("a2", 8'h10, 3);

        // Timeout after the first payload byte.
        any_wr = 1'b0;
        send_byte(8'hA5); send_byte(8'hFE); send_byte(8'h02); send_byte(8'hAA);
        for (int i = 0; i < int'(TMO) - 1; i++) begin
            any_wr = any_wr | wr_en;
            @(negedge clk);
        end
        check_val("tmo.early_err", {31'd0, err}, 32'd0);
        check_val("tmo.early_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_val("tmo.no_wr", {31'd0, any_wr}, 32'd0);
        expect_err("tmo", 2'b11);

        // A byte on the expiry cycle is accepted: FE^02^AA^BB = ED.
        set_pl(8'hAA, 8'hBB, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'hFE); send_byte(8'h02); send_byte(8'hAA);
        repeat (int'(TMO) - 1) @(negedge clk);
        check_val("exp.early_err", {31'd0, err}, 32'd0);
        send_byte(8'hBB);
        check_val("exp.err", {31'd0, err}, 32'd0);
`ifdef UART_CMD_CHECKSUM_EN
        check_val("exp.busy", {31'd0, busy}, 32'd1);
        send_byte(8'hED);
`endif
        expect_commit("exp", 8'hFE, 2);

        // Address wrap: FF^02^01^02 = FE.
        set_pl(8'h01, 8'h02, 8'h00, 8'h00);
        send_frame(8'hFF, 2, 8'hFE);
        expect_commit("wrap", 8'hFF, 2);

        // SYNC inside the payload is data: 30^02^A5^A5 = 32.
        set_pl(8'hA5, 8'hA5, 8'h00, 8'h00);
        send_frame(8'h30, 2, 8'h32);
        expect_commit("syncdata", 8'h30, 2);

        // Reset during the second of four commit writes: 20^04^01^02^04^08 = 2B.
        set_pl(8'h01, 8'h02, 8'h04, 8'h08);
        send_frame(8'h20, 4, 8'h2B);
        check_val("rstc.w0_en", {31'd0, wr_en}, 32'd1);
        check_val("rstc.w0_addr", {24'd0, wr_addr}, 32'h20);
        @(negedge clk);
        check_val("rstc.w1_en", {31'd0, wr_en}, 32'd1);
        check_val("rstc.w1_data", {24'd0, wr_data}, 32'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rstc.wr_en", {31'd0, wr_en}, 32'd0);
        check_val("rstc.addr", {24'd0, wr_addr}, 32'd0);
        check_val("rstc.data", {24'd0, wr_data}, 32'd0);
        check_val("rstc.busy", {31'd0, busy}, 32'd0);
        check_val("rstc.done", {31'd0, done}, 32'd0);
        check_val("rstc.code", {30'd0, err_code}, 32'd0);
        any_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            any_wr = any_wr | wr_en | done | err | busy;
            @(negedge clk);
        end
        check_val("rstc.quiet", {31'd0, any_wr}, 32'd0);

        // Junk bytes in IDLE.
        any_wr = 1'b0;
        send_byte(8'h00); any_wr = any_wr | wr_en | busy | err | done;
        send_byte(8'h5A); any_wr = any_wr | wr_en | busy | err | done;
        send_byte(8'hFF); any_wr = any_wr | wr_en | busy | err | done;
        send_byte(8'h11); any_wr = any_wr | wr_en | busy | err | done;
        repeat (3) begin
            @(negedge clk);
            any_wr = any_wr | wr_en | busy | err | done;
        end
        check_val("junk.quiet", {31'd0, any_wr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
